ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 147 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control-bundle pipeline (E, M, W ...) with per-stage stall, flush and bubble insertion
//
// Parameters:
//   WIDTH   control-bundle width per stage (1..64)
//   STAGES  number of pipeline register stages (1..8)
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset
//   ctrl_in     decoded control bundle from the source stage
//   valid_in    ctrl_in holds a real instruction
//   stall_src   source stage stalled, insert a bubble into stage 0
//   stall       per-stage stall request, bit k = stage k
//   flush       per-stage flush request, bit k = stage k
//   ctrl_out    stage k bundle at [k*WIDTH +: WIDTH], zero when invalid
//   valid_out   stage k holds a real instruction
//   hold_out    effective hold per stage (combinational)
//   stall_cnt   cycles with any hold_out bit set
//   bubble_cnt  bubbles inserted into the pipe
// Configuration:
//   CTRL_PIPE_PERF_EN  when defined, stall_cnt/bubble_cnt count (saturating);
//                      otherwise both are tied to zero.

module ctrl_pipe #(
    parameter int WIDTH  = 22,
    parameter int STAGES = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          ctrl_in,
    input  logic                      valid_in,
    input  logic                      stall_src,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES*WIDTH-1:0]   ctrl_out,
    output logic [STAGES-1:0]         valid_out,
    output logic [STAGES-1:0]         hold_out,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               bubble_cnt
);

    logic [WIDTH-1:0]  r_ctrl [STAGES];
    logic [STAGES-1:0] r_valid;

    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_bub_cond;
    logic [STAGES-1:0] w_src_valid;
    logic [WIDTH-1:0]  w_src_ctrl [STAGES];

    // A stall anywhere downstream back-pressures every upstream stage.
    always_comb begin
        w_hold = '0;
        w_hold[STAGES-1] = stall[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_hold[k] = stall[k] | w_hold[k+1];
        end
    end

    assign hold_out = w_hold;

    // What each stage would load when neither flushed nor held.
    // Invalid inputs are zeroed here so ctrl is always 0 on invalid entries.
    always_comb begin
        w_bub_cond     = '0;
        w_src_valid    = '0;
        w_src_ctrl[0]  = valid_in ? ctrl_in : '0;
        w_src_valid[0] = valid_in;
        w_bub_cond[0]  = stall_src;
        for (int k = 1; k < STAGES; k++) begin
            w_src_ctrl[k]  = r_ctrl[k-1];
            w_src_valid[k] = r_valid[k-1];
            // Upstream is held, so its contents stay put; feed a bubble forward.
            w_bub_cond[k]  = w_hold[k-1];
        end
    end

    // Priority per stage: flush > hold > bubble > load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_ctrl[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush[k]) begin
                    r_ctrl[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end else if (w_hold[k]) begin
                    r_ctrl[k]  <= r_ctrl[k];
                    r_valid[k] <= r_valid[k];
                end else if (w_bub_cond[k]) begin
                    r_ctrl[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end else begin
                    r_ctrl[k]  <= w_src_ctrl[k];
                    r_valid[k] <= w_src_valid[k];
                end
            end
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int k = 0; k < STAGES; k++) begin
            ctrl_out[k*WIDTH +: WIDTH] = r_ctrl[k];
        end
    end

    assign valid_out = r_valid;

`ifdef CTRL_PIPE_PERF_EN
    logic [STAGES-1:0] w_bubble;
    logic [31:0]       w_bub_inc;
    logic [32:0]       w_bub_sum;
    logic [32:0]       w_stall_sum;
    logic [31:0]       r_stall_cnt;
    logic [31:0]       r_bubble_cnt;

    // A bubble is counted only when the bubble branch actually wins.
    always_comb begin
        w_bub_inc = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_bubble[k] = !flush[k] && !w_hold[k] && w_bub_cond[k];
            w_bub_inc   = w_bub_inc + 32'(w_bubble[k]);
        end
        w_bub_sum   = {1'b0, r_bubble_cnt} + {1'b0, w_bub_inc};
        w_stall_sum = {1'b0, r_stall_cnt} + 33'(|w_hold);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_stall_cnt  <= w_stall_sum[32] ? 32'hFFFF_FFFF : w_stall_sum[31:0];
            r_bubble_cnt <= w_bub_sum[32]   ? 32'hFFFF_FFFF : w_bub_sum[31:0];
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - self-checking scoreboard bench for ctrl_pipe

module tb_ctrl_pipe;

    localparam int W = 22;
    localparam int S = 3;

    logic             clk;
    logic             rst;
    logic [W-1:0]     ctrl_in;
    logic             valid_in;
    logic             stall_src;
    logic [S-1:0]     stall;
    logic [S-1:0]     flush;
    logic [S*W-1:0]   ctrl_out;
    logic [S-1:0]     valid_out;
    logic [S-1:0]     hold_out;
    logic [31:0]      stall_cnt;
    logic [31:0]      bubble_cnt;

    ctrl_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_in    (ctrl_in),
        .valid_in   (valid_in),
        .stall_src  (stall_src),
        .stall      (stall),
        .flush      (flush),
        .ctrl_out   (ctrl_out),
        .valid_out  (valid_out),
        .hold_out   (hold_out),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_chk  = 0;
    int           n_pass = 0;
    logic [W-1:0] sb [$];
    logic         sb_en  = 1'b0;
    logic         ld2    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] st_ctrl(input int k);
        return ctrl_out[k*W +: W];
    endfunction

    // Apply one cycle of inputs; push to the scoreboard only when stage 0 consumes a real item.
    task automatic cyc(input logic [W-1:0] c, input logic v, input logic ss,
                       input logic [S-1:0] st, input logic [S-1:0] fl);
        ctrl_in   = c;
        valid_in  = v;
        stall_src = ss;
        stall     = st;
        flush     = fl;
        if (sb_en && v && !ss && (st == '0) && !fl[0]) sb.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rst_pulse();
        ctrl_in = '0; valid_in = 0; stall_src = 0; stall = '0; flush = '0;
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Stage 2 presents a new entry only on edges where it was not held or flushed.
    always @(posedge clk) ld2 <= rst && !hold_out[S-1] && !flush[S-1];

    always @(negedge clk) begin
        if (sb_en && ld2 && valid_out[S-1]) begin
            if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
            else check("sb_out", 64'(st_ctrl(S-1)), 64'(sb.pop_front()));
        end
    end

    initial begin
        logic [W-1:0] cur_c;
        logic         cur_v;
        logic         ss;
        logic [S-1:0] st;

        rst = 1'b0; ctrl_in = '0; valid_in = 0; stall_src = 0; stall = '0; flush = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_ctrl", 64'(ctrl_out), 64'd0);
        check("rst_cnt", {stall_cnt, bubble_cnt}, 64'd0);
        rst = 1'b1;

        // Single instruction walks E, M, W
        sb_en = 1'b1;
        cyc(22'h15A5A5, 1, 0, '0, '0);
        check("lat_s0_ctrl", 64'(st_ctrl(0)), 64'h15A5A5);
        check("lat_s0_valid", 64'(valid_out), 64'b001);
        idle(1);
        check("lat_s1_ctrl", 64'(st_ctrl(1)), 64'h15A5A5);
        check("lat_s1_valid", 64'(valid_out), 64'b010);
        idle(1);
        check("lat_s2_ctrl", 64'(st_ctrl(2)), 64'h15A5A5);
        check("lat_s2_valid", 64'(valid_out), 64'b100);
        idle(1);
        check("lat_empty", 64'(valid_out), 64'd0);

        // Stream A,B,C then stall[1] for two cycles
        rst_pulse();
        cyc(22'h0000A1, 1, 0, '0, '0);
        cyc(22'h0000B2, 1, 0, '0, '0);
        cyc(22'h0000C3, 1, 0, '0, '0);
        cyc('0, 0, 0, 3'b010, '0);
        check("st1_hold", 64'(hold_out), 64'b011);
        cyc('0, 0, 0, 3'b010, '0);
        check("st1_valid", 64'(valid_out), 64'b011);
        check("st1_s0", 64'(st_ctrl(0)), 64'h0000C3);
        check("st1_s1", 64'(st_ctrl(1)), 64'h0000B2);
        check("st1_s2", 64'(st_ctrl(2)), 64'd0);
`ifdef CTRL_PIPE_PERF_EN
        check("st1_bub_cnt", 64'(bubble_cnt), 64'd2);
        check("st1_stall_cnt", 64'(stall_cnt), 64'd2);
`else
        check("st1_cnt_off", {stall_cnt, bubble_cnt}, 64'd0);
`endif
        idle(3);
        check("st1_drained", 64'(valid_out), 64'd0);

        // Source stall for one cycle inserts a single bubble
        rst_pulse();
        cyc(22'h000AAA, 1, 0, '0, '0);
        cyc(22'h000BBB, 1, 1, '0, '0);
        check("src_valid", 64'(valid_out), 64'b010);
        check("src_s0", 64'(st_ctrl(0)), 64'd0);
        cyc(22'h000BBB, 1, 0, '0, '0);
        check("src_valid2", 64'(valid_out), 64'b101);
        idle(3);
`ifdef CTRL_PIPE_PERF_EN
        check("src_bub_cnt", 64'(bubble_cnt), 64'd1);
`else
        check("src_cnt_off", 64'(bubble_cnt), 64'd0);
`endif

        // Flush stage 1 while stage 2 stalls
        rst_pulse();
        sb_en = 1'b0;
        cyc(22'h000011, 1, 0, '0, '0);
        cyc(22'h000022, 1, 0, '0, '0);
        cyc(22'h000033, 1, 0, '0, '0);
        cyc(22'h000044, 1, 0, 3'b100, 3'b010);
        check("fl_hold", 64'(hold_out), 64'b111);
        check("fl_valid", 64'(valid_out), 64'b101);
        check("fl_s0", 64'(st_ctrl(0)), 64'h000033);
        check("fl_s1", 64'(st_ctrl(1)), 64'd0);
        check("fl_s2", 64'(st_ctrl(2)), 64'h000011);
`ifdef CTRL_PIPE_PERF_EN
        check("fl_bub_cnt", 64'(bubble_cnt), 64'd0);
`endif

        // Invalid input with nonzero ctrl stores zero
        cyc(22'h3FFFFF, 0, 0, '0, '0);
        check("inv_s0_ctrl", 64'(st_ctrl(0)), 64'd0);
        check("inv_s0_valid", 64'(valid_out[0]), 64'd0);

        // Asynchronous reset mid-cycle with full pipe, then resume
        cyc(22'h000055, 1, 0, '0, '0);
        cyc(22'h000066, 1, 0, '0, '0);
        cyc(22'h000077, 1, 0, '0, '0);
        check("ar_full", 64'(valid_out), 64'b111);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", 64'(valid_out), 64'd0);
        check("ar_ctrl", 64'(ctrl_out), 64'd0);
        check("ar_cnt", {stall_cnt, bubble_cnt}, 64'd0);
        @(negedge clk);
        ctrl_in = 22'h000E0E; valid_in = 1; stall = '0; flush = '0; stall_src = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ar_resume_valid", 64'(valid_out), 64'b001);
        check("ar_resume_s0", 64'(st_ctrl(0)), 64'h000E0E);

        // Random stream, no flushes: order must be preserved through stalls and bubbles
        rst_pulse();
        sb_en = 1'b1;
        cur_c = 22'($urandom);
        cur_v = 1'($urandom_range(0, 1));
        for (int i = 0; i < 80; i++) begin
            ss = ($urandom_range(0, 4) == 0);
            st = ($urandom_range(0, 3) == 0) ? S'($urandom_range(1, 7)) : '0;
            cyc(cur_c, cur_v, ss, st, '0);
            if (!ss && st == '0) begin
                cur_c = 22'($urandom);
                cur_v = 1'($urandom_range(0, 1));
            end
        end
        idle(5);
        check("sb_empty", 64'(sb.size()), 64'd0);

        // Counter saturation
        rst_pulse();
`ifdef CTRL_PIPE_PERF_EN
        @(negedge clk);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        for (int i = 0; i < 3; i++) cyc('0, 0, 0, 3'b001, '0);
        check("sat_stall_cnt", 64'(stall_cnt), 64'hFFFF_FFFF);
`else
        for (int i = 0; i < 3; i++) cyc('0, 0, 0, 3'b001, '0);
        check("off_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
